wishbone_reg_slave: RTL
=======================

# wishbone_reg_slave

Wishbone pipelined-mode slave exposing a bank of 32-bit read/write registers at the responder end of the platform's Wishbone interconnect. It accepts one request at a time and inserts a configurable number of wait states. It answers every accepted in-range access with a single-cycle `wb_ack` and every out-of-range or misaligned access with a single-cycle `wb_err`. Register 0 is also driven out to hardware as a control word.

## Interface
- `NREGS`, default 8: number of 32-bit registers, 1..256.
- `WAIT_STATES`, default 1: idle cycles between request acceptance and response, 0..15.
- `BASE_ADDR`, default 32'h0000_0000: byte address of register 0. Must be 4-byte aligned.

Ports:
- `wb_clk` in 1: clock. One clock domain; everything is on the rising edge.
- `wb_rst` in 1: reset, asynchronous and active-low.
- `wb_cyc` in 1: bus cycle active.
- `wb_stb` in 1: request strobe.
- `wb_we` in 1: 1 = write, 0 = read.
- `wb_sel` in 4: byte-lane enables. Bit n covers `dat[8n+7:8n]`.
- `wb_adr` in 32: byte address.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data.
- `wb_ack` out 1: normal termination.
- `wb_err` out 1: error termination.
- `wb_stall` out 1: slave cannot accept a request this cycle.
- `ctrl_o` out 32: continuous copy of register 0.

## Operation
State machine:
- **IDLE**
  - `wb_stall`=0.
  - A request is accepted when `wb_cyc`&`wb_stb` are high in IDLE.
  - On acceptance, `wb_we`, `wb_sel`, `wb_adr` and `wb_dat_i` are latched.
  - Next state is WAIT if `WAIT_STATES`>0, else RESP.
- **WAIT**
  - `wb_stall`=1.
  - The counter loads `WAIT_STATES`-1 on entry and decrements each cycle.
  - Moves to RESP when the counter is 0.
  - If `wb_cyc`=0 in any WAIT cycle: abort to IDLE. No response, no register change.
- **RESP**
  - One cycle only, `wb_stall`=1.
  - Exactly one of `wb_ack`/`wb_err` is asserted.
  - Always returns to IDLE, even if `wb_cyc` dropped during this cycle.

Decode of the latched address:
- offset = adr − `BASE_ADDR`, computed as 32-bit unsigned with wrap.
- index = offset[31:2].
- Error when `adr[1:0]`≠0, or when index ≥ `NREGS`. This includes adr < `BASE_ADDR`, since the wrapped offset is then huge.

Write with ack:
- Only lanes with `sel`=1 are updated.
- `sel`=4'b0000 still acks, with no change.
- The update occurs on the clock edge that enters RESP.

Read with ack:
- `wb_dat_o` = register[index], latched on the edge entering RESP.
- `sel` is ignored for reads; the full word is returned.

Error accesses never modify any register. `wb_dat_o` is 0 in every cycle except an acked read's RESP cycle.

## Timing
- Reset (`wb_rst`=0, asynchronous):
  - State goes to IDLE.
  - All registers are 0, `ctrl_o`=0, `wb_dat_o`=0.
  - `wb_ack`=0, `wb_err`=0, `wb_stall`=0.
- Reset asserted mid-transaction: the transaction is dropped with no response.
- Latency: if the request is accepted in cycle T, the response is in cycle T+`WAIT_STATES`+1.
- Throughput: the next acceptance is earliest at cycle T+`WAIT_STATES`+2. Back-to-back peak is one transfer per `WAIT_STATES`+2 cycles.
- `wb_ack`, `wb_err` and `wb_stall` are registered outputs, not combinational from inputs.
- `ctrl_o` reflects a write to register 0 from the RESP cycle onward.
- Requests presented while `wb_stall`=1 are ignored. The master holds them, per pipelined Wishbone.

## Test plan
1. **Write then read, defaults.** Write 32'hDEAD_BEEF to adr 0x4 with sel=4'hF, accepted at T.
   - `wb_ack` is high only at T+2.
   - Read of 0x4: `wb_dat_o`=32'hDEAD_BEEF in its ack cycle, 0 in all other cycles.
2. **Byte lanes.** Register 0 holds 32'h1122_3344. Write 32'hAABB_CCDD with sel=4'b0101.
   - `ctrl_o`=32'h11BB_33DD.
   - A further write with sel=4'b0000 acks and leaves `ctrl_o` unchanged.
3. **Errors.** Each of the following gives `wb_err`=1 for one cycle, `wb_ack`=0, and no register change:
   - NREGS=8, adr 0x20.
   - adr 0x6.
   - BASE_ADDR=0x100, adr 0xFC.
4. **Abort.** WAIT_STATES=3; write to adr 0x8, then drop `wb_cyc` one cycle after acceptance.
   - No ack and no err.
   - Register 2 is unchanged.
   - `wb_stall` is 0 on the next cycle.
5. **Back-to-back and stall.** WAIT_STATES=0; hold `wb_stb` high for reads of 0x0, 0x4 and 0x8.
   - Acceptances occur every 2 cycles.
   - `wb_stall` alternates 0/1.
   - Three acks are returned with the correct data, in order.
6. **Reset mid-operation.** Pulse `wb_rst` low during WAIT after writes to registers 0..7.
   - All outputs are 0 immediately, without waiting for a clock.
   - A subsequent read of every register returns 0.

Source files
------------

// File: rtl/wishbone_reg_slave.sv
// Wishbone pipelined-mode slave with NREGS 32-bit read/write registers.
// One request at a time, WAIT_STATES idle cycles, then a single-cycle ack or err.
module wishbone_reg_slave #(
  parameter int          NREGS       = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        wb_stall,
  output logic [31:0] ctrl_o
);

  localparam int         IW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_to_resp;

  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;

  logic        r_ack;
  logic        r_err;
  logic        r_stall;
  logic [31:0] r_dat_o;
  logic [31:0] r_regs [NREGS];

  logic        w_accept;
  logic        w_cur_we;
  logic [3:0]  w_cur_sel;
  logic [31:0] w_cur_adr;
  logic [31:0] w_cur_dat;
  logic [31:0] w_offset;
  logic        w_bad;
  logic [IW-1:0] w_idx;

  assign w_accept = (r_state == S_IDLE) && wb_cyc && wb_stb;

  // With zero wait states the access completes on the accepting edge, so the
  // decode must look at the live bus in IDLE and at the latched copy otherwise.
  assign w_cur_we  = (r_state == S_IDLE) ? wb_we    : r_we;
  assign w_cur_sel = (r_state == S_IDLE) ? wb_sel   : r_sel;
  assign w_cur_adr = (r_state == S_IDLE) ? wb_adr   : r_adr;
  assign w_cur_dat = (r_state == S_IDLE) ? wb_dat_i : r_dat;

  // BASE_ADDR is word aligned, so offset[1:0] equals adr[1:0]; an address
  // below the base wraps to a huge index and fails the range test.
  assign w_offset = w_cur_adr - BASE_ADDR;
  assign w_bad    = (w_offset[1:0] != 2'b00) || (w_offset[31:2] >= 30'(NREGS));
  assign w_idx    = w_offset[IW+1:2];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_to_resp   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES > 0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WS_LOAD;
          end else begin
            w_state_nxt = S_RESP;
            w_to_resp   = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
          w_to_resp   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_stall <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_to_resp && !w_bad;
      r_err   <= w_to_resp && w_bad;
      r_stall <= (w_state_nxt != S_IDLE);
      r_dat_o <= (w_to_resp && !w_bad && !w_cur_we) ? r_regs[w_idx] : '0;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (w_accept) begin
      r_we  <= wb_we;
      r_sel <= wb_sel;
      r_adr <= wb_adr;
      r_dat <= wb_dat_i;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_to_resp && !w_bad && w_cur_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_cur_sel[b]) r_regs[w_idx][8*b +: 8] <= w_cur_dat[8*b +: 8];
      end
    end
  end

  assign wb_ack   = r_ack;
  assign wb_err   = r_err;
  assign wb_stall = r_stall;
  assign wb_dat_o = r_dat_o;
  assign ctrl_o   = r_regs[0];

endmodule
